// File: rtl/remainder_division_pkg.sv
// rtl/remainder_division_pkg.sv - shared width, state encoding and step count for the long divider
package remainder_division_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two quotient bits retire per clock, so the step count is half the width.
  function automatic int step_count(input int width);
    return width / 2;
  endfunction

  localparam int STEPS_DEF = WIDTH_DEF / 2;

endpackage

// File: rtl/remainder_long_division_div_step.sv
// rtl/remainder_long_division_div_step.sv - one combinational restoring division step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             n_bit,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Compare at WIDTH+1 bits: the shifted remainder can exceed the width when d is large.
  always_comb begin
    shifted = {rem, n_bit};
    diff    = shifted - {1'b0, d};
    q_bit   = (shifted >= {1'b0, d});
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/remainder_long_division.sv
// rtl/remainder_long_division.sv - iterative unsigned divider, two quotient bits per clock
module remainder_long_division
  import remainder_division_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  input  logic             VALID,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             READY,
  output logic             div_zero_err
);

  localparam int STEPS = step_count(WIDTH);
  localparam int CNT_W = $clog2(STEPS + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, d_q, rem_q, quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_1, rem_2;
  logic             qb_1, qb_2;
  logic             last_step;

  div_step #(.WIDTH(WIDTH)) u_step_hi (
    .rem      (rem_q),
    .n_bit    (n_q[WIDTH-1]),
    .d        (d_q),
    .rem_next (rem_1),
    .q_bit    (qb_1)
  );

  div_step #(.WIDTH(WIDTH)) u_step_lo (
    .rem      (rem_1),
    .n_bit    (n_q[WIDTH-2]),
    .d        (d_q),
    .rem_next (rem_2),
    .q_bit    (qb_2)
  );

  assign last_step = (cnt_q == CNT_W'(1));
  assign READY     = (state_q == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (VALID) state_d = (D == '0) ? DONE : BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (!VALID) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_q          <= '0;
      d_q          <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
      Q            <= '0;
      R            <= '0;
      div_zero_err <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (VALID) begin
            n_q   <= N;
            d_q   <= D;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= CNT_W'(STEPS);
            // Divide by zero short-circuits straight to a defined result.
            if (D == '0) begin
              Q            <= '1;
              R            <= N;
              div_zero_err <= 1'b1;
            end else begin
              div_zero_err <= 1'b0;
            end
          end
        end
        BUSY: begin
          n_q   <= {n_q[WIDTH-3:0], 2'b00};
          rem_q <= rem_2;
          quo_q <= {quo_q[WIDTH-3:0], qb_1, qb_2};
          cnt_q <= cnt_q - CNT_W'(1);
          if (last_step) begin
            Q <= {quo_q[WIDTH-3:0], qb_1, qb_2};
            R <= rem_2;
          end
        end
        DONE: begin
          if (!VALID) div_zero_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_remainder_long_division.sv
// tb/tb_remainder_long_division.sv - directed vector bench for remainder_long_division
module tb_remainder_long_division;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] N = '0;
  logic [31:0] D = '0;
  logic        VALID = 1'b0;
  logic [31:0] Q, R;
  logic        READY, div_zero_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] n;
    logic [31:0] d;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[$];

  remainder_long_division dut (
    .clk          (clk),
    .reset        (reset),
    .N            (N),
    .D            (D),
    .VALID        (VALID),
    .Q            (Q),
    .R            (R),
    .READY        (READY),
    .div_zero_err (div_zero_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v, input int idx);
    int lat;
    logic [31:0] q_snap;
    lat = 0;
    @(negedge clk);
    N = v.n;
    D = v.d;
    VALID = 1'b1;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (READY) lat = i;
    end
    chk($sformatf("v%0d_latency", idx), lat, (v.d == 0) ? 32'd1 : 32'd17);
    chk($sformatf("v%0d_q", idx), Q, v.q);
    chk($sformatf("v%0d_r", idx), R, v.r);
    chk($sformatf("v%0d_dz", idx), {31'b0, div_zero_err}, {31'b0, v.dz});
    q_snap = Q;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_ready_hold", idx), {31'b0, READY}, 32'd1);
    chk($sformatf("v%0d_q_hold", idx), Q, v.q);
    @(negedge clk);
    VALID = 1'b0;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_ready_drop", idx), {31'b0, READY}, 32'd0);
    chk($sformatf("v%0d_dz_drop", idx), {31'b0, div_zero_err}, 32'd0);
    chk($sformatf("v%0d_q_idle", idx), Q, q_snap);
  endtask

  initial begin
    int lat;
    vecs.push_back('{32'd50,         32'd2,          32'd25,         32'd0,          1'b0});
    vecs.push_back('{32'd51,         32'd2,          32'd25,         32'd1,          1'b0});
    vecs.push_back('{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0});
    vecs.push_back('{32'h55555555,   32'hFFFFFFFF,   32'd0,          32'h55555555,   1'b0});
    vecs.push_back('{32'hAAAAAAAA,   32'd1,          32'hAAAAAAAA,   32'd0,          1'b0});
    vecs.push_back('{32'd0,          32'd1,          32'd0,          32'd0,          1'b0});
    vecs.push_back('{32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,          1'b1});
    vecs.push_back('{32'h00001234,   32'd0,          32'hFFFFFFFF,   32'h00001234,   1'b1});
    vecs.push_back('{32'h11111111,   32'h000000FF,   32'h00112233,   32'h00000044,   1'b0});
    vecs.push_back('{32'hFFFFFFFF,   32'h0000BEEF,   32'h0001573D,   32'h0000480C,   1'b0});
    vecs.push_back('{32'hFFFFFFFF,   32'hBEEFBEEF,   32'd1,          32'h41104110,   1'b0});
    vecs.push_back('{32'd7,          32'd9,          32'd0,          32'd7,          1'b0});
    vecs.push_back('{32'h12345678,   32'h12345678,   32'd1,          32'd0,          1'b0});

    repeat (2) @(posedge clk);
    #1;
    chk("reset_q", Q, 32'd0);
    chk("reset_r", R, 32'd0);
    chk("reset_ready", {31'b0, READY}, 32'd0);
    chk("reset_dz", {31'b0, div_zero_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) do_op(vecs[i], i);

    // Operand changes during BUSY must not disturb the latched copies.
    @(negedge clk);
    N = 32'd51;
    D = 32'd2;
    VALID = 1'b1;
    @(posedge clk);
    @(negedge clk);
    N = 32'hFFFFFFFF;
    D = 32'd0;
    lat = 0;
    for (int i = 2; i <= 40 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (READY) lat = i;
    end
    chk("busy_ignore_latency", lat, 32'd17);
    chk("busy_ignore_q", Q, 32'd25);
    chk("busy_ignore_r", R, 32'd1);
    chk("busy_ignore_dz", {31'b0, div_zero_err}, 32'd0);
    @(negedge clk);
    VALID = 1'b0;
    @(posedge clk);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    N = 32'd1000;
    D = 32'd7;
    VALID = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midop_busy_ready", {31'b0, READY}, 32'd0);
    reset = 1'b0;
    #1;
    chk("midop_reset_q", Q, 32'd0);
    chk("midop_reset_r", R, 32'd0);
    chk("midop_reset_ready", {31'b0, READY}, 32'd0);
    VALID = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_idle", {31'b0, READY}, 32'd0);
    do_op('{32'd1000, 32'd7, 32'd142, 32'd6, 1'b0}, 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
